// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter fed by an internal FIFO. A producer pushes words with a
// valid/ready handshake; queued words are framed back to back
// (start, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits)
// with no idle gap while the FIFO holds data.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> parity_mode port, PARITY state and parity
//                                   generation are present.
//                      undefined -> no parity_mode port, frames never carry a
//                                   parity bit.
//
// Ports:
//   sys_clk       in   clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   tx_valid      in   producer has a word on tx_data
//   tx_data       in   [DATA_BITS-1:0] word to send, LSB first on the line
//   tx_ready      out  FIFO can accept (not full), combinational
//   parity_mode   in   [1:0] 00 none, 01 odd, 10 even, 11 none (option only)
//   fifo_level    out  [AW:0] number of queued words
//   uart_tx_busy  out  registered: FSM active or words queued
//   uart_txd      out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                  parity_mode,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        uart_tx_busy,
    output logic                        uart_txd
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;

    localparam logic [15:0] BAUD_LAST  = 16'(BPS_CNT - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t                 state;
    logic [15:0]            baud_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;

    logic [DATA_BITS-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   head_word;

    logic push;
    logic pop;
    logic fifo_empty;
    logic baud_end;
    logic frame_end;

`ifdef UART_TX_PARITY_EN
    logic par_en;
    logic par_bit;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (fifo_level == '0);
    assign tx_ready   = (fifo_level != LEVEL_FULL);
    assign push       = tx_valid && tx_ready;
    assign head_word  = fifo_mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop decision: from IDLE, or on the last cycle of the last stop bit so
    // the next start bit follows with no idle gap. The level seen here is the
    // pre-edge value, so a word pushed into an empty FIFO waits one cycle.
    // ------------------------------------------------------------------
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == ST_STOP) && baud_end && (bit_cnt == STOP_LAST);
    assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);

    // Payload shifter and parity bit; loaded at pop time, no reset needed.
    always_ff @(posedge sys_clk) begin
        if (pop) begin
            shift_reg <= head_word;
`ifdef UART_TX_PARITY_EN
            par_bit   <= (parity_mode == 2'b01) ? ~(^head_word) : (^head_word);
`endif
        end else if ((state == ST_DATA) && baud_end) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM. uart_txd is registered from the current state, so the line
    // lags the state by one cycle; every bit still lasts exactly BPS_CNT
    // cycles. uart_tx_busy uses the same lag so it drops together with the
    // line returning to idle.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en       <= 1'b0;
`endif
        end else begin
            uart_tx_busy <= (state != ST_IDLE) || !fifo_empty;

            if (pop) begin
`ifdef UART_TX_PARITY_EN
                par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
`endif
            end

            case (state)
                ST_IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    uart_txd <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    uart_txd <= shift_reg[0];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= par_en ? ST_PARITY : ST_STOP;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    uart_txd <= par_bit;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif

                ST_STOP: begin
                    uart_txd <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= pop ? ST_START : ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    uart_txd <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
